// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register address width, issue kinds and
// fixed producer latencies used by the issue-side hazard logic.
package pipe_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_MUL  = 2'b10,
    KIND_NONE = 2'b11
  } issue_kind_e;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Loadable saturating-at-zero down-counter with a nonzero flag; one per
// tracked register and one for the shared multiplier.
module sb_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_nz
);

  logic [W-1:0] r_cnt;

  // Load wins over the per-cycle decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != {W{1'b0}}) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != {W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard controller: per-register forwarding countdowns, shared
// multiplier sequencing, stall generation and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int MUL_LAT = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [1:0]        issue_kind,
  input  logic [REG_W-1:0]  issue_src1,
  input  logic [REG_W-1:0]  issue_src2,
  input  logic              issue_use1,
  input  logic              issue_use2,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic              issue_wr,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [REG_W-1:0]  mul_dest,
  output logic [STAT_W-1:0] stall_cycles
);

  import pipe_pkg::*;

  localparam int NREG  = 1 << REG_W;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [NREG-1:0]   w_nz;
  logic [CNT_W-1:0]  w_lat;
  logic [CNT_W-1:0]  w_mul_cnt;
  logic              w_mul_nz;
  logic              w_is_mul;
  logic              w_writes;
  logic              w_raw1;
  logic              w_raw2;
  logic              w_waw;
  logic              w_struct;
  logic              w_stall;
  logic              w_fire;
  logic              w_mul_load;
  logic              w_mul_last;
  logic [REG_W-1:0]  r_mul_dest_q;
  logic [REG_W-1:0]  r_mul_dest;
  logic              r_mul_done;
  logic [STAT_W-1:0] r_stall_cycles;

  // Cycles until the new result becomes forwardable, by producer kind
  always_comb begin
    w_lat = {CNT_W{1'b0}};
    case (issue_kind)
      KIND_LOAD: w_lat = CNT_W'(LAT_LOAD);
      KIND_MUL:  w_lat = CNT_W'(MUL_LAT);
      default:   w_lat = CNT_W'(LAT_ALU);
    endcase
  end

  assign w_is_mul = (issue_kind == KIND_MUL);
  assign w_writes = issue_wr && (issue_kind != KIND_NONE) && (issue_dest != {REG_W{1'b0}});
  assign w_raw1   = issue_use1 && (issue_src1 != {REG_W{1'b0}}) && w_nz[issue_src1];
  assign w_raw2   = issue_use2 && (issue_src2 != {REG_W{1'b0}}) && w_nz[issue_src2];
  assign w_waw    = w_writes && (w_cnt[issue_dest] > w_lat);
  // The multiplier's final cycle overlaps issue of the next multiply
  assign w_struct = w_is_mul && (w_mul_cnt > CNT_W'(1));

  assign w_stall    = issue_valid && (w_raw1 || w_raw2 || w_waw || w_struct);
  assign w_fire     = issue_valid && !w_stall && !flush;
  assign w_mul_load = w_fire && w_is_mul;
  assign w_mul_last = (w_mul_cnt == CNT_W'(1));

  assign w_cnt[0] = {CNT_W{1'b0}};
  assign w_nz[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_fire && w_writes && (issue_dest == REG_W'(r))),
      .i_val  (w_lat),
      .o_cnt  (w_cnt[r]),
      .o_nz   (w_nz[r])
    );
  end

  sb_counter #(.W(CNT_W)) u_mul_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_mul_load),
    .i_val  (CNT_W'(MUL_LAT)),
    .o_cnt  (w_mul_cnt),
    .o_nz   (w_mul_nz)
  );

  // Completion pulse; the reported destination is captured separately so a
  // multiply issued in the final cycle cannot overwrite it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_dest_q <= {REG_W{1'b0}};
      r_mul_dest   <= {REG_W{1'b0}};
      r_mul_done   <= 1'b0;
    end else begin
      if (w_mul_load) begin
        r_mul_dest_q <= issue_dest;
      end
      if (w_mul_last) begin
        r_mul_dest <= r_mul_dest_q;
      end
      r_mul_done <= w_mul_last;
    end
  end

  // Squashed instructions do not count as stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {STAT_W{1'b0}};
    end else if (w_stall && !flush && (r_stall_cycles != {STAT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + STAT_W'(1);
    end
  end

  assign stall        = w_stall;
  assign issue_fire   = w_fire;
  assign mul_busy     = w_mul_nz;
  assign mul_done     = r_mul_done;
  assign mul_dest     = r_mul_dest;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-step stall/fire expectations and
// a queue of expected multiplier completions checked every cycle.
module tb_hazard_scoreboard;

  localparam int MUL_LAT  = 4;
  localparam int STAT_W   = 8;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_LOAD = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_NONE = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [1:0]        issue_kind;
  logic [2:0]        issue_src1;
  logic [2:0]        issue_src2;
  logic              issue_use1;
  logic              issue_use2;
  logic [2:0]        issue_dest;
  logic              issue_wr;
  logic              flush;
  logic              stall;
  logic              issue_fire;
  logic              mul_busy;
  logic              mul_done;
  logic [2:0]        mul_dest;
  logic [STAT_W-1:0] stall_cycles;

  hazard_scoreboard #(.REG_W(3), .MUL_LAT(MUL_LAT), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_kind   (issue_kind),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_use1   (issue_use1),
    .issue_use2   (issue_use2),
    .issue_dest   (issue_dest),
    .issue_wr     (issue_wr),
    .flush        (flush),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .mul_busy     (mul_busy),
    .mul_done     (mul_done),
    .mul_dest     (mul_dest),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stat = 0;

  typedef struct {
    logic [2:0] dest;
    int         when;
  } mexp_t;
  mexp_t mq[$];
  mexp_t mhead;
  logic  exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle: mul_done must pulse exactly when the oldest queued multiply is due
  always @(negedge clk) begin
    while (mq.size() > 0 && mq[0].when < cyc) void'(mq.pop_front());
    exp_done = (mq.size() > 0) && (mq[0].when == cyc);
    chk("mul_done", {31'b0, mul_done}, {31'b0, exp_done});
    if (exp_done) begin
      mhead = mq.pop_front();
      chk("mul_dest", {29'b0, mul_dest}, {29'b0, mhead.dest});
    end
  end

  task automatic step(input string tag, input logic v, input logic [1:0] k,
                      input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2,
                      input logic [2:0] d, input logic wr, input logic fl,
                      input logic exp_stall);
    logic exp_fire;
    issue_valid = v;  issue_kind = k;
    issue_src1  = s1; issue_use1 = u1;
    issue_src2  = s2; issue_use2 = u2;
    issue_dest  = d;  issue_wr   = wr;
    flush       = fl;
    exp_fire = v & ~exp_stall & ~fl;
    @(negedge clk);
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
    chk({tag, "_fire"}, {31'b0, issue_fire}, {31'b0, exp_fire});
    if (exp_fire && k == K_MUL) mq.push_back('{dest: d, when: cyc + MUL_LAT + 1});
    if (exp_stall && !fl && exp_stat < STAT_MAX) exp_stat++;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [1:0] k, input logic [2:0] s1,
                    input logic u1, input logic [2:0] d, input logic fl,
                    input logic exp_stall);
    step(tag, 1'b1, k, s1, u1, 3'd0, 1'b0, d, 1'b1, fl, exp_stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, K_NONE, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_kind = K_ALU; issue_src1 = 3'd0; issue_src2 = 3'd0;
    issue_use1 = 1'b0; issue_use2 = 1'b0; issue_dest = 3'd0; issue_wr = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_fire", {31'b0, issue_fire}, 32'd0);
    chk("reset_busy", {31'b0, mul_busy}, 32'd0);
    chk("reset_done", {31'b0, mul_done}, 32'd0);
    chk("reset_stat", {24'b0, stall_cycles}, 32'd0);
    rst_n = 1'b1;

    // ALU result forwards immediately
    op("alu_r1", K_ALU, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    op("alu_use_r1", K_ALU, 3'd1, 1'b1, 3'd7, 1'b0, 1'b0);

    // Load-use: exactly one bubble
    op("load_r2", K_LOAD, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    op("use_r2_bubble", K_ALU, 3'd2, 1'b1, 3'd1, 1'b0, 1'b1);
    op("use_r2_go", K_ALU, 3'd2, 1'b1, 3'd1, 1'b0, 1'b0);
    chk("stat_load_use", {24'b0, stall_cycles}, exp_stat);

    // Multiply-use through src2
    op("mul_r3", K_MUL, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
    chk("mul_busy", {31'b0, mul_busy}, 32'd1);
    for (int i = 0; i < MUL_LAT; i++)
      step("use_r3_wait", 1'b1, K_ALU, 3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    step("use_r3_go", 1'b1, K_ALU, 3'd0, 1'b0, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("stat_mul_use", {24'b0, stall_cycles}, exp_stat);

    // WAW: younger ALU write waits for the pending multiply
    op("mul_r4", K_MUL, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) op("waw_r4_wait", K_ALU, 3'd0, 1'b0, 3'd4, 1'b0, 1'b1);
    op("waw_r4_go", K_ALU, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);

    // Back-to-back multiplies: structural stall of MUL_LAT-1 cycles
    op("mul_r5", K_MUL, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT - 1; i++) op("mul_struct_wait", K_MUL, 3'd0, 1'b0, 3'd6, 1'b0, 1'b1);
    op("mul_r6_go", K_MUL, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    chk("stat_waw_struct", {24'b0, stall_cycles}, exp_stat);

    // Flush during a load-use hazard: stall shown, not counted, nothing fires
    op("load_r2_b", K_LOAD, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    op("flush_hazard", K_ALU, 3'd2, 1'b1, 3'd1, 1'b1, 1'b1);
    op("after_flush", K_ALU, 3'd2, 1'b1, 3'd1, 1'b0, 1'b0);
    chk("stat_flush", {24'b0, stall_cycles}, exp_stat);

    // WAW boundary cnt == lat, and unused sources never stall
    op("load_r2_c", K_LOAD, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    op("load_r2_again", K_LOAD, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    op("nouse_r2", K_ALU, 3'd2, 1'b0, 3'd1, 1'b0, 1'b0);

    // r0 and no-write kinds leave no state behind
    op("load_r0", K_LOAD, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step("read_r0", 1'b1, K_ALU, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    op("mul_r0_use", K_ALU, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
    op("store_r3", K_NONE, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
    op("use_r3_store", K_ALU, 3'd3, 1'b1, 3'd1, 1'b0, 1'b0);
    idle(MUL_LAT + 2);

    // Reset in the middle of a multiply abandons it
    op("mul_r7", K_MUL, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, mul_busy}, 32'd0);
    chk("midrst_done", {31'b0, mul_done}, 32'd0);
    chk("midrst_stat", {24'b0, stall_cycles}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_fire", {31'b0, issue_fire}, 32'd0);
    mq.delete();
    exp_stat = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(MUL_LAT + 4);
    chk("after_rst_stat", {24'b0, stall_cycles}, exp_stat);

    // Drive the stall counter into saturation
    for (int i = 0; i < 70; i++) begin
      op("sat_mul", K_MUL, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
      for (int j = 0; j < MUL_LAT; j++) op("sat_wait", K_ALU, 3'd6, 1'b1, 3'd1, 1'b0, 1'b1);
      op("sat_go", K_ALU, 3'd6, 1'b1, 3'd1, 1'b0, 1'b0);
    end
    chk("stat_saturated", {24'b0, stall_cycles}, exp_stat);
    chk("stat_is_max", {24'b0, stall_cycles}, STAT_MAX);
    op("sat_mul_last", K_MUL, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    op("sat_hold", K_ALU, 3'd6, 1'b1, 3'd1, 1'b0, 1'b1);
    chk("stat_hold", {24'b0, stall_cycles}, STAT_MAX);
    idle(MUL_LAT + 2);

    chk("mul_queue_drained", mq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
